mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between an instruction fetch port and a
// data port. D normally wins; a streak limit keeps I from starving.
module mem_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_readM,
  input  logic [WORD_SIZE-1:0] i_address,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  input  logic                 m_ready,
  output logic [WORD_SIZE-1:0] conflict_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t     state;
  logic [3:0] streak;
  logic       d_req;
  logic       both_req;
  logic       d_wins;

  function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign d_req    = d_readM | d_writeM;
  assign both_req = i_readM & d_req;
  // D keeps priority until I has been passed over MAX_D_STREAK times in a row.
  assign d_wins   = d_req & ~(i_readM & (streak == STREAK_MAX));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      streak       <= 4'd0;
      conflict_cnt <= '0;
      m_readM      <= 1'b0;
      m_writeM     <= 1'b0;
      m_address    <= '0;
      m_wdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (both_req)
            conflict_cnt <= sat_inc(conflict_cnt);
          if (d_wins) begin
            state     <= BUSY_D;
            m_address <= d_address;
            m_wdata   <= d_wdata;
            m_writeM  <= d_writeM;
            m_readM   <= ~d_writeM;
            streak    <= i_readM ? streak + 4'd1 : 4'd0;
          end else if (i_readM) begin
            state     <= BUSY_I;
            m_address <= i_address;
            m_wdata   <= '0;
            m_readM   <= 1'b1;
            m_writeM  <= 1'b0;
            streak    <= 4'd0;
          end else begin
            streak <= 4'd0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (m_ready) begin
            state    <= IDLE;
            m_readM  <= 1'b0;
            m_writeM <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is combinational on m_ready; m_writeM is still high in that cycle.
  assign i_ready = (state == BUSY_I) & m_ready;
  assign d_ready = (state == BUSY_D) & m_ready;
  assign i_rdata = i_ready ? m_rdata : '0;
  assign d_rdata = (d_ready & ~m_writeM) ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a memory responder, two requester queues and a
// transaction-level reference model checked every cycle, plus directed scenarios.
module tb_mem_arbiter;
  localparam int W    = 16;
  localparam int MAXD = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_readM = 1'b0;
  logic [W-1:0] i_address = '0;
  logic [W-1:0] i_rdata;
  logic         i_ready;
  logic         d_readM = 1'b0;
  logic         d_writeM = 1'b0;
  logic [W-1:0] d_address = '0;
  logic [W-1:0] d_wdata = '0;
  logic [W-1:0] d_rdata;
  logic         d_ready;
  logic         m_readM;
  logic         m_writeM;
  logic [W-1:0] m_address;
  logic [W-1:0] m_wdata;
  logic [W-1:0] m_rdata = '0;
  logic         m_ready = 1'b0;
  logic [W-1:0] conflict_cnt;

  mem_arbiter #(.WORD_SIZE(W), .MAX_D_STREAK(MAXD)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_readM(i_readM), .i_address(i_address), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] addr;
    logic         rd;
    logic         wr;
    logic [W-1:0] wdata;
  } djob_t;

  int total = 0;
  int bad = 0;

  logic [W-1:0] mem  [256];
  logic [W-1:0] gold [256];
  logic [W-1:0] i_q[$];
  djob_t        d_q[$];
  int           comp_log[$];

  bit gaps = 0;
  bit rst_req = 1;
  bit spur_next = 0;
  int spur_rate = 0;
  int force_lat = 0;
  int scnt = 0;
  int lat = 2;
  bit i_done = 0;
  bit d_done = 0;

  int           owner = 0;
  logic [W-1:0] t_addr = '0;
  logic [W-1:0] t_wdata = '0;
  bit           t_write = 0;
  int           streak = 0;
  int           conf = 0;

  int           mread_cycles = 0;
  int           write_done = 0;
  logic [W-1:0] last_i_rdata = '0;
  logic [W-1:0] last_d_rdata = '0;
  logic [W-1:0] last_m_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int log_code();
    int c = 0;
    foreach (comp_log[k]) c = c * 10 + comp_log[k];
    return c;
  endfunction

  // Compare this cycle's outputs with the model, then advance the model over the edge.
  task automatic observe();
    bit exp_i, exp_d, dreq;
    exp_i = (owner == 1) && m_ready;
    exp_d = (owner == 2) && m_ready;
    chk("i_ready", i_ready, exp_i);
    chk("d_ready", d_ready, exp_d);
    chk("m_readM", m_readM, (owner == 1) || (owner == 2 && !t_write));
    chk("m_writeM", m_writeM, (owner == 2) && t_write);
    chk("conflict_cnt", conflict_cnt, conf);
    if (owner != 0) chk("m_address", m_address, t_addr);
    if (owner == 2 && t_write) chk("m_wdata", m_wdata, t_wdata);
    if (exp_i) chk("i_rdata", i_rdata, gold[t_addr[7:0]]);
    if (exp_d) chk("d_rdata", d_rdata, t_write ? '0 : gold[t_addr[7:0]]);

    if (i_ready) begin i_done = 1; comp_log.push_back(1); last_i_rdata = i_rdata; end
    if (d_ready) begin d_done = 1; comp_log.push_back(2); last_d_rdata = d_rdata; end
    if (m_readM) mread_cycles++;
    if (m_writeM) last_m_wdata = m_wdata;
    if (m_writeM && m_ready) write_done++;

    if (!reset_n) begin
      owner = 0; streak = 0; conf = 0;
    end else if (owner != 0) begin
      if (m_ready) begin
        if (owner == 2 && t_write) gold[t_addr[7:0]] = t_wdata;
        owner = 0;
      end
    end else begin
      dreq = d_readM || d_writeM;
      if (i_readM && dreq && conf < 65535) conf++;
      if (dreq && !(i_readM && streak >= MAXD)) begin
        owner = 2; t_addr = d_address; t_write = d_writeM; t_wdata = d_wdata;
        streak = i_readM ? streak + 1 : 0;
      end else if (i_readM) begin
        owner = 1; t_addr = i_address; t_write = 0; streak = 0;
      end else begin
        streak = 0;
      end
    end
  endtask

  task automatic tick();
    djob_t j;
    @(posedge clk);
    #1;
    reset_n = ~rst_req;
    if (m_readM || m_writeM) begin
      if (scnt == 0) lat = (force_lat > 0) ? force_lat : int'($urandom_range(2, 4));
      scnt++;
      if (scnt >= lat) begin
        m_ready = 1'b1;
        if (m_writeM) begin
          mem[m_address[7:0]] = m_wdata;
          m_rdata = W'($urandom);
        end else begin
          m_rdata = mem[m_address[7:0]];
        end
      end else begin
        m_ready = 1'b0;
        m_rdata = W'($urandom);
      end
    end else begin
      scnt = 0;
      m_ready = spur_next || (spur_rate > 0 && $urandom_range(0, spur_rate - 1) == 0);
      spur_next = 0;
      m_rdata = W'($urandom);
    end

    if (rst_req) begin
      i_readM = 0; d_readM = 0; d_writeM = 0; i_done = 0; d_done = 0;
    end else begin
      if (i_done) begin i_readM = 0; i_done = 0; end
      if (d_done) begin d_readM = 0; d_writeM = 0; d_done = 0; end
      if (!i_readM && i_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        i_readM = 1;
        i_address = i_q.pop_front();
      end
      if (!(d_readM || d_writeM) && d_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        j = d_q.pop_front();
        d_readM = j.rd; d_writeM = j.wr; d_address = j.addr; d_wdata = j.wdata;
      end
    end
    if (!i_readM) i_address = W'($urandom);
    if (!(d_readM || d_writeM)) begin d_address = W'($urandom); d_wdata = W'($urandom); end
    @(negedge clk);
    observe();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((i_q.size() > 0 || d_q.size() > 0 || i_readM || d_readM || d_writeM) && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic do_reset();
    i_q.delete(); d_q.delete();
    rst_req = 1; tick(); rst_req = 0; tick();
  endtask

  task automatic push_d(input logic [W-1:0] a, input logic rd, input logic wr, input logic [W-1:0] wd);
    djob_t j;
    j.addr = a; j.rd = rd; j.wr = wr; j.wdata = wd;
    d_q.push_back(j);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < 256; k++) begin
      mem[k] = W'(k * 37 + 5);
      gold[k] = mem[k];
    end

    // Reset state: every output low, counter cleared.
    rst_req = 1;
    tick(); tick();
    chk("rst_m_readM", m_readM, 0);
    chk("rst_m_writeM", m_writeM, 0);
    chk("rst_m_address", m_address, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_conflict", conflict_cnt, 0);
    rst_req = 0;
    tick();

    // I-only read, two-cycle memory.
    mem[16] = 16'h1234; gold[16] = 16'h1234;
    force_lat = 2; mread_cycles = 0; comp_log.delete();
    i_q.push_back(16'h0010);
    drain("i_read", 50);
    chk("i_read_data", last_i_rdata, 16'h1234);
    chk("i_read_strobe_cycles", mread_cycles, 2);
    chk("i_read_log", log_code(), 1);

    // D write then D read back.
    comp_log.delete(); force_lat = 0;
    push_d(16'h0020, 0, 1, 16'hBEEF);
    push_d(16'h0020, 1, 0, 16'h0000);
    drain("d_wr_rd", 50);
    chk("d_wr_wdata", last_m_wdata, 16'hBEEF);
    chk("d_rd_data", last_d_rdata, 16'hBEEF);
    chk("d_wr_rd_log", log_code(), 22);

    // Simultaneous I and D from IDLE.
    do_reset(); comp_log.delete();
    i_q.push_back(16'h0040);
    push_d(16'h0041, 1, 0, 16'h0000);
    drain("simul", 50);
    chk("simul_order", log_code(), 21);
    chk("simul_conflict", conflict_cnt, 1);

    // I held while D keeps re-requesting: streak limit lets I in after 4 D grants.
    do_reset(); comp_log.delete();
    i_q.push_back(16'h0050);
    for (int k = 0; k < 5; k++) push_d(W'(16'h0060 + k), 1, 0, 16'h0000);
    drain("streak", 100);
    chk("streak_order", log_code(), 222212);
    chk("streak_conflict", conflict_cnt, 5);
    chk("streak_model_clear", streak, 0);

    // Reset while BUSY_D, memory answers one cycle after the reset edge.
    do_reset(); comp_log.delete(); force_lat = 10;
    push_d(16'h0070, 1, 0, 16'h0000);
    n = 0;
    while (!m_readM && n < 10) begin tick(); n++; end
    chk("abort_busy_reached", m_readM, 1);
    rst_req = 1; tick();
    rst_req = 0; spur_next = 1; tick();
    force_lat = 0;
    chk("abort_m_ready_seen", m_ready, 1);
    chk("abort_d_ready", d_ready, 0);
    chk("abort_d_rdata", d_rdata, 0);
    chk("abort_m_readM", m_readM, 0);
    chk("abort_m_writeM", m_writeM, 0);
    chk("abort_m_address", m_address, 0);
    chk("abort_conflict", conflict_cnt, 0);
    chk("abort_log", comp_log.size(), 0);
    tick();

    // Read and write together: write only, single completion, no read data.
    comp_log.delete(); mread_cycles = 0; write_done = 0;
    push_d(16'h0030, 1, 1, 16'h00AA);
    drain("rdwr", 50);
    chk("rdwr_log", log_code(), 2);
    chk("rdwr_d_rdata", last_d_rdata, 0);
    chk("rdwr_writes", write_done, 1);
    chk("rdwr_no_read", mread_cycles, 0);
    chk("rdwr_mem", mem[8'h30], 16'h00AA);

    // Randomized traffic with gaps, stray m_ready pulses and occasional resets.
    gaps = 1; spur_rate = 8;
    for (int c = 0; c < 4000; c++) begin
      if (i_q.size() < 2 && $urandom_range(0, 3) == 0)
        i_q.push_back(W'($urandom_range(0, 15)));
      if (d_q.size() < 2 && $urandom_range(0, 2) == 0) begin
        logic [1:0] op;
        op = 2'($urandom_range(1, 3));
        push_d(W'($urandom_range(0, 15)), op[0], op[1], W'($urandom));
      end
      if ($urandom_range(0, 599) == 0) begin
        i_q.delete(); d_q.delete();
        rst_req = 1;
      end
      tick();
      rst_req = 0;
    end
    spur_rate = 0;
    drain("random_drain", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
